int_sync_crossing_source_vec: RTL and testbench
===============================================

// Module: int_sync_crossing_source_vec
// PURPOSE
//  Source half of an interrupt clock-domain crossing, generalised to NUM_INTS
//  channels. Each channel is either a level channel or an edge channel.
//  - Level channels: the input is registered once on async-reset flops.
//  - Edge channels: rising edges are delivered as a 4-phase req/ack handshake
//    to the sink domain, so short pulses are never lost.
//  Sits at the interrupt-source side of a tile or peripheral boundary. Its
//  outputs drive an int_sync_crossing_sink in a different clock domain.
// PARAMETERS
//  NUM_INTS        4     number of interrupt channels (1..32)
//  EDGE_MASK       '0    NUM_INTS-bit vector; bit i=1 makes channel i an edge channel
//  ACK_SYNC_STAGES 3     synchroniser depth on the returning ack (2..4)
//  CNT_W           8     width of the saturating coalesce counter
// PORTS
//  clock           in   1         source-domain clock
//  reset           in   1         asynchronous, active-high reset
//  auto_in         in   NUM_INTS  interrupt inputs, synchronous to clock
//  auto_in_ack     in   NUM_INTS  ack from sink domain (asynchronous); used on edge channels only
//  auto_out_sync   out  NUM_INTS  level value (level channel) or req (edge channel)
//  pending         out  NUM_INTS  edge captured but not yet sent; always 0 on level channels
//  coalesce_cnt    out  CNT_W     saturating count of edges merged into an already-pending edge
//  cnt_clr         in   1         synchronous clear of coalesce_cnt
// BEHAVIOUR
//  Reset (async assert, released on clock):
//   - auto_out_sync=0, pending=0, coalesce_cnt=0.
//   - prev-input flops=0 and ack synchroniser=0.
//  Level channel i:
//   - auto_out_sync[i] <= auto_in[i] every cycle; latency 1 cycle.
//   - auto_in_ack[i] is ignored.
//  Edge channel i:
//   - edge_i = auto_in[i] & ~prev[i].
//   - prev resets to 0, so an input held high at reset release counts as one edge.
//   - ack_s[i] = auto_in_ack[i] after ACK_SYNC_STAGES flops.
//  Handshake FSM per edge channel:
//   - IDLE (req=0, ack_s=0): if edge_i or pending[i], then req<=1 and pending<=0
//     -> REQ. Latency from edge to req is 1 cycle.
//   - REQ (req=1): wait for ack_s=1, then req<=0 -> WAIT_LOW.
//   - WAIT_LOW (req=0, ack_s=1): wait for ack_s=0 -> IDLE.
//   - No new req is raised until ack_s is low.
//  Edge arriving outside IDLE:
//   - pending[i] was 0: pending<=1.
//   - pending[i] was 1: edge is coalesced and coalesce_cnt increments.
//  Edge in IDLE while pending=1: req<=1 and pending stays 1 (the old pending is
//   consumed, the new edge becomes pending); no count.
//  Counter rules:
//   - Several channels coalescing in the same cycle add their popcount.
//   - Saturates at 2^CNT_W-1 and never wraps.
//   - cnt_clr has priority over increment in the same cycle: result is 0.
//  Reset mid-handshake: req drops immediately and pending is lost. The sink is
//   reset by the same system reset, so no recovery protocol is defined.
//  Glitch rule: auto_out_sync must come straight from flops, with no
//   combinational logic after the register.
// STRUCTURE
//  - Shared package int_xing_pkg:
//    - typedef hs_state_e {HS_IDLE, HS_REQ, HS_WAIT_LOW};
//    - localparam MAX_INTS=32.
//  - One sub-module, int_edge_handshake: one edge channel with its synchroniser,
//    FSM and pending flop. It outputs req, pending and a coalesce strobe.
//  - Top level:
//    - generate loop over channels, selected by EDGE_MASK;
//    - level channels use plain async-reset flops;
//    - popcount of the strobes feeds the saturating counter.
//  - Assertion: EDGE_MASK has no bits set above NUM_INTS-1.
// TESTING
//  1. NUM_INTS=4, EDGE_MASK=0: auto_in=4'b1010 at cycle 5 -> auto_out_sync=4'b1010
//     at cycle 6. auto_in_ack toggling has no effect.
//  2. EDGE_MASK=4'b0001, ack loops back after 2 cycles of sink delay: 1-cycle pulse
//     on auto_in[0] -> req high 1 cycle later, held until ack_s is high, then low.
//     Exactly one req per pulse.
//  3. Ack held low, 3 pulses on ch0: 1st pulse raises req, 2nd sets pending, 3rd
//     gives coalesce_cnt=1. Releasing ack -> a second req after WAIT_LOW, then pending=0.
//  4. Counter, CNT_W=2: 5 coalesced edges -> coalesce_cnt=3 (saturated). cnt_clr in
//     the same cycle as an increment -> 0.
//  5. Reset during REQ with pending=1 -> auto_out_sync and pending go to 0 without
//     waiting for a clock. After release with auto_in[0] held high -> one req.
//  6. Ch0 and ch2 edge channels, both coalescing in the same cycle -> coalesce_cnt
//     increases by 2. Level ch1 is unaffected throughout.

Source files
------------

// File: rtl/int_xing_pkg.sv
// Shared types and helpers for the interrupt clock-domain crossing blocks.
package int_xing_pkg;

    localparam int MAX_INTS = 32;

    // Per-channel four-phase handshake states on the source side.
    typedef enum logic [1:0] {
        HS_IDLE     = 2'd0,
        HS_REQ      = 2'd1,
        HS_WAIT_LOW = 2'd2
    } hs_state_e;

    // Number of set bits in a channel vector (0..MAX_INTS fits in 6 bits).
    function automatic logic [5:0] popcount(input logic [MAX_INTS-1:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < MAX_INTS; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/int_edge_handshake.sv
// One edge-triggered interrupt channel: rising-edge detect, ack synchroniser,
// four-phase req/ack FSM and a single pending slot. A strobe reports edges
// that had to be merged into an already-pending edge.
module int_edge_handshake
    import int_xing_pkg::*;
#(
    parameter int ACK_SYNC_STAGES = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic irq,
    input  logic ack,
    output logic req,
    output logic pending,
    output logic coalesce
);

    logic [ACK_SYNC_STAGES-1:0] ack_sync_r;
    logic                       ack_s;
    logic                       prev_r;
    logic                       edge_s;
    logic                       can_fire_s;
    logic                       req_r;
    logic                       pend_r;
    hs_state_e                  state_r;
    hs_state_e                  state_nxt_s;
    logic                       req_nxt_s;
    logic                       pend_nxt_s;
    logic                       coal_s;

    assign ack_s      = ack_sync_r[ACK_SYNC_STAGES-1];
    assign edge_s     = irq & ~prev_r;
    // A new request may only start once the previous ack has fully returned low.
    assign can_fire_s = (state_r == HS_IDLE) && !ack_s;

    // Bring the asynchronous ack into the source clock domain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack_sync_r <= {ACK_SYNC_STAGES{1'b0}};
        end else begin
            ack_sync_r <= {ack_sync_r[ACK_SYNC_STAGES-2:0], ack};
        end
    end

    // Next-state, request, pending-slot and coalesce decisions.
    always_comb begin
        state_nxt_s = state_r;
        req_nxt_s   = req_r;
        pend_nxt_s  = pend_r;
        coal_s      = 1'b0;
        if (can_fire_s) begin
            if (edge_s || pend_r) begin
                req_nxt_s   = 1'b1;
                state_nxt_s = HS_REQ;
                // An old pending edge is consumed; a fresh edge takes its place.
                pend_nxt_s  = edge_s & pend_r;
            end else begin
                state_nxt_s = HS_IDLE;
            end
        end else begin
            if (edge_s) begin
                if (pend_r) begin
                    coal_s = 1'b1;
                end else begin
                    pend_nxt_s = 1'b1;
                end
            end else begin
                pend_nxt_s = pend_r;
            end
            case (state_r)
                HS_REQ: begin
                    if (ack_s) begin
                        req_nxt_s   = 1'b0;
                        state_nxt_s = HS_WAIT_LOW;
                    end else begin
                        state_nxt_s = HS_REQ;
                    end
                end
                HS_WAIT_LOW: begin
                    if (!ack_s) begin
                        state_nxt_s = HS_IDLE;
                    end else begin
                        state_nxt_s = HS_WAIT_LOW;
                    end
                end
                HS_IDLE: begin
                    state_nxt_s = HS_IDLE;
                end
                default: begin
                    state_nxt_s = HS_IDLE;
                    req_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    // Handshake state, request, pending slot and previous-input registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= HS_IDLE;
            req_r   <= 1'b0;
            pend_r  <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            req_r   <= req_nxt_s;
            pend_r  <= pend_nxt_s;
            prev_r  <= irq;
        end
    end

    // req goes straight from its flop to the crossing, keeping it glitch-free.
    assign req      = req_r;
    assign pending  = pend_r;
    assign coalesce = coal_s;

endmodule

// File: rtl/int_sync_crossing_source_vec_chk.sv
// Static and run-time sanity checks for the interrupt crossing source.
module int_sync_crossing_source_vec_chk
    import int_xing_pkg::*;
#(
    parameter int                   NUM_INTS  = 4,
    parameter logic [MAX_INTS-1:0]  EDGE_MASK = {MAX_INTS{1'b0}}
) (
    input logic                clock,
    input logic                reset,
    input logic [NUM_INTS-1:0] pending
);

    // Channel selection must not reference channels that do not exist.
    a_edge_mask_in_range: assert property (@(posedge clock) disable iff (reset)
        ((EDGE_MASK >> NUM_INTS) == {MAX_INTS{1'b0}}))
        else $error("EDGE_MASK selects channels above NUM_INTS-1");

    // Level channels never hold a pending edge.
    a_level_never_pending: assert property (@(posedge clock) disable iff (reset)
        ((pending & ~EDGE_MASK[NUM_INTS-1:0]) == {NUM_INTS{1'b0}}))
        else $error("pending set on a level channel");

endmodule

// File: rtl/int_sync_crossing_source_vec.sv
// Source half of a multi-channel interrupt clock-domain crossing. Level
// channels are registered once; edge channels use a req/ack handshake so short
// pulses survive the crossing. Edges merged into an already-pending edge are
// counted in a saturating counter.
module int_sync_crossing_source_vec
    import int_xing_pkg::*;
#(
    parameter int                  NUM_INTS        = 4,
    parameter logic [MAX_INTS-1:0] EDGE_MASK       = {MAX_INTS{1'b0}},
    parameter int                  ACK_SYNC_STAGES = 3,
    parameter int                  CNT_W           = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_INTS-1:0] auto_in,
    input  logic [NUM_INTS-1:0] auto_in_ack,
    output logic [NUM_INTS-1:0] auto_out_sync,
    output logic [NUM_INTS-1:0] pending,
    output logic [CNT_W-1:0]    coalesce_cnt,
    input  logic                cnt_clr
);

    localparam int                 SUM_W     = CNT_W + 6;
    localparam logic [SUM_W-1:0]   CNT_MAX_W = {{6{1'b0}}, {CNT_W{1'b1}}};

    logic [NUM_INTS-1:0] coal_s;
    logic [MAX_INTS-1:0] coal_wide_s;
    logic [5:0]          inc_s;
    logic [SUM_W-1:0]    sum_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;

    for (genvar i = 0; i < NUM_INTS; i++) begin : g_ch
        if (EDGE_MASK[i]) begin : g_edge
            int_edge_handshake #(
                .ACK_SYNC_STAGES(ACK_SYNC_STAGES)
            ) u_hs (
                .clock    (clock),
                .reset    (reset),
                .irq      (auto_in[i]),
                .ack      (auto_in_ack[i]),
                .req      (auto_out_sync[i]),
                .pending  (pending[i]),
                .coalesce (coal_s[i])
            );
        end else begin : g_level
            logic level_r;
            logic unused_ack_s;

            // Level channel: one register stage, the ack is not part of the protocol.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    level_r <= 1'b0;
                end else begin
                    level_r <= auto_in[i];
                end
            end

            assign auto_out_sync[i] = level_r;
            assign pending[i]       = 1'b0;
            assign coal_s[i]        = 1'b0;
            assign unused_ack_s     = auto_in_ack[i];
        end
    end

    // Add this cycle's coalesced edges to the counter, saturating; clear wins.
    always_comb begin
        coal_wide_s                 = {MAX_INTS{1'b0}};
        coal_wide_s[NUM_INTS-1:0]   = coal_s;
        inc_s                       = popcount(coal_wide_s);
        sum_s                       = {6'd0, cnt_r} + {{(SUM_W-6){1'b0}}, inc_s};
        if (cnt_clr) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (sum_s > CNT_MAX_W) begin
            cnt_nxt_s = {CNT_W{1'b1}};
        end else begin
            cnt_nxt_s = sum_s[CNT_W-1:0];
        end
    end

    // Coalesce counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign coalesce_cnt = cnt_r;

    int_sync_crossing_source_vec_chk #(
        .NUM_INTS  (NUM_INTS),
        .EDGE_MASK (EDGE_MASK)
    ) u_chk (
        .clock   (clock),
        .reset   (reset),
        .pending (pending)
    );

endmodule

// File: tb/tb_int_sync_crossing_source_vec.sv
// Bench for the interrupt crossing source: a mixed edge/level instance
// (channels 0 and 2 edge, 2-bit counter) and an all-level instance.
module tb_int_sync_crossing_source_vec;

    localparam logic [3:0] EM = 4'b0101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a_in = 4'd0, a_ack = 4'd0;
    logic       clr = 1'b0;
    logic [3:0] a_out, a_pend;
    logic [1:0] a_cnt;
    logic [3:0] l_in = 4'd0, l_ack = 4'd0;
    logic       l_clr = 1'b0;
    logic [3:0] l_out, l_pend;
    logic [7:0] l_cnt;

    always #5 clk = ~clk;

    int_sync_crossing_source_vec #(
        .NUM_INTS(4), .EDGE_MASK(32'h0000_0005), .ACK_SYNC_STAGES(3), .CNT_W(2)
    ) dut_e (
        .clock(clk), .reset(rst), .auto_in(a_in), .auto_in_ack(a_ack),
        .auto_out_sync(a_out), .pending(a_pend), .coalesce_cnt(a_cnt), .cnt_clr(clr)
    );

    int_sync_crossing_source_vec #(
        .NUM_INTS(4), .EDGE_MASK(32'h0000_0000), .ACK_SYNC_STAGES(3), .CNT_W(8)
    ) dut_l (
        .clock(clk), .reset(rst), .auto_in(l_in), .auto_in_ack(l_ack),
        .auto_out_sync(l_out), .pending(l_pend), .coalesce_cnt(l_cnt), .cnt_clr(l_clr)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0 = free, 1 = request up, 2 = waiting for ack low.
    bit [3:0] m_prev, m_req, m_pend, m_lvl, l_exp;
    int       m_phase[4];
    bit [3:0] m_ackh[3];   // ack inputs seen 1, 2, 3 edges ago
    int       m_cnt;
    bit [3:0] loop_en, ack_man, rq1, rq2;

    function automatic logic [3:0] exp_out();
        return (m_req & EM) | (m_lvl & ~EM);
    endfunction

    task automatic model_reset();
        m_prev = 4'd0; m_req = 4'd0; m_pend = 4'd0; m_lvl = 4'd0; l_exp = 4'd0;
        for (int i = 0; i < 4; i++) m_phase[i] = 0;
        for (int i = 0; i < 3; i++) m_ackh[i] = 4'd0;
        m_cnt = 0; rq1 = 4'd0; rq2 = 4'd0;
    endtask

    task automatic model_edge();
        int inc;
        bit e;
        bit [3:0] acks;
        inc = 0;
        acks = m_ackh[2];
        for (int i = 0; i < 4; i++) begin
            if (EM[i]) begin
                e = a_in[i] & ~m_prev[i];
                if (m_phase[i] == 0 && !acks[i]) begin
                    if (e || m_pend[i]) begin
                        m_req[i] = 1'b1; m_phase[i] = 1; m_pend[i] = e & m_pend[i];
                    end
                end else begin
                    if (e) begin
                        if (m_pend[i]) inc++;
                        else m_pend[i] = 1'b1;
                    end
                    if (m_phase[i] == 1 && acks[i]) begin
                        m_req[i] = 1'b0; m_phase[i] = 2;
                    end else if (m_phase[i] == 2 && !acks[i]) begin
                        m_phase[i] = 0;
                    end
                end
            end
        end
        if (clr) m_cnt = 0;
        else m_cnt = (m_cnt + inc > 3) ? 3 : m_cnt + inc;
        m_lvl = a_in; m_prev = a_in; l_exp = l_in;
        m_ackh[2] = m_ackh[1]; m_ackh[1] = m_ackh[0]; m_ackh[0] = a_ack;
    endtask

    task automatic set_ack();
        a_ack = (loop_en & rq2) | (~loop_en & ack_man);
    endtask

    // One clock: model follows the edge, sink loopback echoes req two cycles later.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        rq2 = rq1; rq1 = a_out;
        set_ack();
    endtask

    task automatic drain();
        a_in = 4'd0; clr = 1'b0; loop_en = EM; ack_man = 4'd0; set_ack();
        repeat (40) tick();
    endtask

    task automatic test_reset();
        checks++;
        if ({a_out, a_pend, a_cnt} !== 10'd0) begin
            failures++; $display("FAIL reset_edge_dut: got %b_%b_%b want all zero", a_out, a_pend, a_cnt);
        end
        checks++;
        if ({l_out, l_pend, l_cnt} !== 16'd0) begin
            failures++; $display("FAIL reset_level_dut: got %b_%b_%h want all zero", l_out, l_pend, l_cnt);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_level();
        for (int c = 0; c < 12; c++) begin
            l_in  = (c == 5) ? 4'b1010 : 4'($urandom);
            l_ack = 4'($urandom);
            tick();
            checks++;
            if ({l_out, l_pend, l_cnt} !== {l_exp, 4'd0, 8'd0}) begin
                failures++; $display("FAIL level_cycle c=%0d: got out=%b pend=%b cnt=%0d want out=%b pend=0 cnt=0", c, l_out, l_pend, l_cnt, l_exp);
            end
            if (c == 5) begin
                checks++;
                if (l_out !== 4'b1010) begin
                    failures++; $display("FAIL level_latency: got %b want 1010", l_out);
                end
            end
        end
    endtask

    task automatic test_pulse();
        int rises;
        bit prev;
        rises = 0; prev = 1'b0;
        loop_en = EM; ack_man = 4'd0; set_ack();
        for (int c = 0; c < 22; c++) begin
            a_in[0] = (c == 1);
            tick();
            checks++;
            if ({a_out, a_pend, a_cnt} !== {exp_out(), m_pend, m_cnt[1:0]}) begin
                failures++; $display("FAIL pulse_cycle c=%0d: got out=%b pend=%b cnt=%0d want out=%b pend=%b cnt=%0d", c, a_out, a_pend, a_cnt, exp_out(), m_pend, m_cnt);
            end
            if (c == 1) begin
                checks++;
                if (a_out[0] !== 1'b1) begin
                    failures++; $display("FAIL pulse_req_latency: got %b want 1", a_out[0]);
                end
            end
            if (a_out[0] && !prev) rises++;
            prev = a_out[0];
        end
        checks++;
        if (rises != 1 || a_out[0] !== 1'b0) begin
            failures++; $display("FAIL pulse_one_req: got rises=%0d req=%b want rises=1 req=0", rises, a_out[0]);
        end
    endtask

    task automatic test_coalesce();
        int rises;
        bit prev;
        loop_en = 4'd0; ack_man = 4'd0; set_ack(); a_in = 4'd0;
        clr = 1'b1; tick(); clr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            a_in[0] = (c % 2 == 0);
            tick();
            checks++;
            if ({a_out, a_pend, a_cnt} !== {exp_out(), m_pend, m_cnt[1:0]}) begin
                failures++; $display("FAIL coal_cycle c=%0d: got out=%b pend=%b cnt=%0d want out=%b pend=%b cnt=%0d", c, a_out, a_pend, a_cnt, exp_out(), m_pend, m_cnt);
            end
            if (c == 0 || c == 2 || c == 4) begin
                checks++;
                if ((c == 0 && a_out[0] !== 1'b1) || (c == 2 && a_pend[0] !== 1'b1) || (c == 4 && a_cnt !== 2'd1)) begin
                    failures++; $display("FAIL coal_step c=%0d: got req=%b pend=%b cnt=%0d", c, a_out[0], a_pend[0], a_cnt);
                end
            end
        end
        rises = 0; prev = a_out[0];
        for (int c = 0; c < 14; c++) begin
            ack_man[0] = (c < 6); set_ack();
            tick();
            checks++;
            if ({a_out, a_pend, a_cnt} !== {exp_out(), m_pend, m_cnt[1:0]}) begin
                failures++; $display("FAIL coal_release c=%0d: got out=%b pend=%b cnt=%0d want out=%b pend=%b cnt=%0d", c, a_out, a_pend, a_cnt, exp_out(), m_pend, m_cnt);
            end
            if (a_out[0] && !prev) rises++;
            prev = a_out[0];
        end
        checks++;
        if (rises != 1 || a_out[0] !== 1'b1 || a_pend[0] !== 1'b0) begin
            failures++; $display("FAIL coal_second_req: got rises=%0d req=%b pend=%b want 1 1 0", rises, a_out[0], a_pend[0]);
        end
        drain();
    endtask

    task automatic test_counter_sat();
        loop_en = 4'd0; ack_man = 4'd0; set_ack(); a_in = 4'd0;
        clr = 1'b1; tick(); clr = 1'b0;
        for (int c = 0; c < 14; c++) begin
            a_in[0] = (c % 2 == 0);
            tick();
            checks++;
            if ({a_out, a_pend, a_cnt} !== {exp_out(), m_pend, m_cnt[1:0]}) begin
                failures++; $display("FAIL sat_cycle c=%0d: got out=%b pend=%b cnt=%0d want out=%b pend=%b cnt=%0d", c, a_out, a_pend, a_cnt, exp_out(), m_pend, m_cnt);
            end
        end
        checks++;
        if (a_cnt !== 2'd3) begin
            failures++; $display("FAIL sat_value: got %0d want 3", a_cnt);
        end
        a_in[0] = 1'b1; clr = 1'b1;
        tick();
        checks++;
        if (a_cnt !== 2'd0 || m_cnt != 0) begin
            failures++; $display("FAIL sat_clr_priority: got %0d want 0", a_cnt);
        end
        clr = 1'b0; a_in = 4'd0; tick();
        drain();
    endtask

    task automatic test_reset_mid();
        int rises;
        bit prev;
        loop_en = 4'd0; ack_man = 4'd0; set_ack();
        for (int c = 0; c < 4; c++) begin
            a_in[0] = (c % 2 == 0);
            tick();
        end
        checks++;
        if ({a_out[0], a_pend[0]} !== 2'b11) begin
            failures++; $display("FAIL mid_setup: got req=%b pend=%b want 1 1", a_out[0], a_pend[0]);
        end
        #1; rst = 1'b1; a_in[0] = 1'b1; model_reset();
        #1;
        checks++;
        if ({a_out, a_pend, a_cnt} !== 10'd0) begin
            failures++; $display("FAIL mid_async_reset: got out=%b pend=%b cnt=%0d want all zero", a_out, a_pend, a_cnt);
        end
        @(negedge clk); rst = 1'b0;
        loop_en = EM; set_ack();
        rises = 0; prev = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if ({a_out, a_pend, a_cnt} !== {exp_out(), m_pend, m_cnt[1:0]}) begin
                failures++; $display("FAIL mid_cycle c=%0d: got out=%b pend=%b cnt=%0d want out=%b pend=%b cnt=%0d", c, a_out, a_pend, a_cnt, exp_out(), m_pend, m_cnt);
            end
            if (a_out[0] && !prev) rises++;
            prev = a_out[0];
        end
        checks++;
        if (rises != 1) begin
            failures++; $display("FAIL mid_one_req: got %0d reqs want 1", rises);
        end
        drain();
    endtask

    task automatic test_dual();
        loop_en = 4'd0; ack_man = 4'd0; set_ack(); a_in = 4'd0;
        clr = 1'b1; tick(); clr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            a_in[0] = (c % 2 == 0); a_in[2] = (c % 2 == 0);
            a_in[1] = 1'($urandom); a_in[3] = 1'b0;
            tick();
            checks++;
            if ({a_out, a_pend, a_cnt} !== {exp_out(), m_pend, m_cnt[1:0]}) begin
                failures++; $display("FAIL dual_cycle c=%0d: got out=%b pend=%b cnt=%0d want out=%b pend=%b cnt=%0d", c, a_out, a_pend, a_cnt, exp_out(), m_pend, m_cnt);
            end
        end
        checks++;
        if (a_cnt !== 2'd2) begin
            failures++; $display("FAIL dual_popcount: got %0d want 2", a_cnt);
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) begin
                loop_en = 4'($urandom) & EM;
            end
            ack_man = 4'($urandom); set_ack();
            a_in = 4'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            l_in = 4'($urandom); l_ack = 4'($urandom);
            tick();
            checks++;
            if ({a_out, a_pend, a_cnt} !== {exp_out(), m_pend, m_cnt[1:0]}) begin
                failures++; $display("FAIL rand_cycle c=%0d: got out=%b pend=%b cnt=%0d want out=%b pend=%b cnt=%0d", c, a_out, a_pend, a_cnt, exp_out(), m_pend, m_cnt);
            end
            checks++;
            if ({l_out, l_pend, l_cnt} !== {l_exp, 4'd0, 8'd0}) begin
                failures++; $display("FAIL rand_level c=%0d: got out=%b pend=%b cnt=%0d want out=%b", c, l_out, l_pend, l_cnt, l_exp);
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        model_reset();
        loop_en = 4'd0; ack_man = 4'd0;
        repeat (3) tick();
        test_reset();
        test_level();
        test_pulse();
        test_coalesce();
        test_counter_sat();
        test_reset_mid();
        test_dual();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
